// File: rtl/mem_traffic_profiler_pkg.sv
// Shared types and helpers for the memory traffic profiler.
//   - mem_prof_op_e         : op class counted per port (LD/ST/AMOSWAP/AMOOR/OTHER)
//   - mem_prof_packet_op_e  : manycore op_v2 encoding carried in request packets
//   - packet layout helpers : packet width and op_v2 bit position
// Packet layout, MSB to LSB:
//   addr | op_v2(4) | reg_id(5) | payload(data) | src_y | src_x | y | x
package mem_traffic_profiler_pkg;

    typedef enum logic [2:0] {
        e_prof_ld,
        e_prof_st,
        e_prof_amoswap,
        e_prof_amoor,
        e_prof_other
    } mem_prof_op_e;

    localparam int unsigned mem_prof_num_ops_gp      = 5;
    localparam int unsigned mem_prof_op_v2_width_gp  = 4;
    localparam int unsigned mem_prof_reg_id_width_gp = 5;

    typedef enum logic [3:0] {
        e_remote_load,
        e_remote_store,
        e_remote_sw,
        e_cache_op,
        e_remote_amoswap,
        e_remote_amoadd,
        e_remote_amoxor,
        e_remote_amoand,
        e_remote_amoor,
        e_remote_amomin,
        e_remote_amomax,
        e_remote_amominu,
        e_remote_amomaxu
    } mem_prof_packet_op_e;

    function automatic int unsigned mem_prof_packet_width(input int unsigned addr_w,
                                                          input int unsigned data_w,
                                                          input int unsigned x_w,
                                                          input int unsigned y_w);
        return addr_w + mem_prof_op_v2_width_gp + mem_prof_reg_id_width_gp
               + data_w + 2 * (x_w + y_w);
    endfunction

    function automatic int unsigned mem_prof_op_v2_lsb(input int unsigned data_w,
                                                       input int unsigned x_w,
                                                       input int unsigned y_w);
        return mem_prof_reg_id_width_gp + data_w + 2 * (x_w + y_w);
    endfunction

    function automatic int unsigned mem_prof_safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic mem_prof_op_e mem_prof_decode_op(input logic [3:0] op_v2);
        case (op_v2)
            e_remote_load:    return e_prof_ld;
            e_remote_store:   return e_prof_st;
            e_remote_amoswap: return e_prof_amoswap;
            e_remote_amoor:   return e_prof_amoor;
            default:          return e_prof_other;
        endcase
    endfunction

endpackage

// File: rtl/mem_traffic_profiler_if.sv
// Request-tap and stat-record stream bundle for mem_traffic_profiler.
//   packet_v_i/packet_i/packet_yumi_i : tapped per-port request handshakes (port 0 in LSBs)
//   stat_*_o                          : record stream produced by the profiler
//   stat_yumi_i                       : consumer accept of the current record
// Modports: master = profiler side, slave = environment side.
interface mem_traffic_profiler_if
    import mem_traffic_profiler_pkg::*;
#(
    parameter int unsigned data_width_p   = 32,
    parameter int unsigned addr_width_p   = 28,
    parameter int unsigned x_cord_width_p = 7,
    parameter int unsigned y_cord_width_p = 7,
    parameter int unsigned num_ports_p    = 1,
    parameter int unsigned ctr_width_p    = 32
) ();

    localparam int unsigned port_id_width_lp = mem_prof_safe_clog2(num_ports_p);
    localparam int unsigned packet_width_lp  =
        mem_prof_packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);

    logic [num_ports_p-1:0]                 packet_v_i;
    logic [num_ports_p*packet_width_lp-1:0] packet_i;
    logic [num_ports_p-1:0]                 packet_yumi_i;

    logic                        stat_v_o;
    logic [data_width_p-1:0]     stat_tag_o;
    logic [31:0]                 stat_ctr_o;
    logic [port_id_width_lp-1:0] stat_port_o;
    logic [2:0]                  stat_op_o;
    logic [ctr_width_p-1:0]      stat_count_o;
    logic                        stat_last_o;
    logic                        stat_yumi_i;

    modport master (
        input  packet_v_i, packet_i, packet_yumi_i, stat_yumi_i,
        output stat_v_o, stat_tag_o, stat_ctr_o, stat_port_o, stat_op_o,
               stat_count_o, stat_last_o
    );

    modport slave (
        output packet_v_i, packet_i, packet_yumi_i, stat_yumi_i,
        input  stat_v_o, stat_tag_o, stat_ctr_o, stat_port_o, stat_op_o,
               stat_count_o, stat_last_o
    );

endinterface

// File: rtl/mem_traffic_prof_counter.sv
// Single event counter for the traffic profiler.
//   clk, reset : clock, synchronous active-high reset
//   incr       : count one event on the next edge
//   count      : current value
//   sat        : (MEM_TRAFFIC_PROFILER_SATURATE_EN only) counter is pinned at all-ones
// Wraps modulo 2^ctr_width_p by default; saturates when
// MEM_TRAFFIC_PROFILER_SATURATE_EN is defined.
module mem_traffic_prof_counter #(
    parameter int unsigned ctr_width_p = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   incr,
    output logic [ctr_width_p-1:0] count
`ifdef MEM_TRAFFIC_PROFILER_SATURATE_EN
    ,
    output logic                   sat
`endif
);

`ifdef MEM_TRAFFIC_PROFILER_SATURATE_EN
    assign sat = &count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (incr && !sat) begin
            count <= count + ctr_width_p'(1);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (incr) begin
            count <= count + ctr_width_p'(1);
        end
    end
`endif

endmodule

// File: rtl/mem_traffic_profiler.sv
// Multi-port memory request traffic profiler.
// Counts accepted request packets per port and per op class, and on a
// snapshot request streams every counter out as a valid/yumi record stream.
//   clk_i, reset_i    : clock, synchronous active-high reset
//   ifc (master)      : tapped request handshakes in, stat record stream out
//   global_ctr_i      : timestamp latched with each snapshot
//   print_stat_v_i    : snapshot request (ignored, and flagged, while dumping)
//   print_stat_tag_i  : tag latched with each snapshot
//   busy_o            : a dump is in progress
//   overrun_o         : sticky, a request arrived while busy
// Records are ordered port-major, op-minor.
// Optional: MEM_TRAFFIC_PROFILER_SATURATE_EN makes counters saturate instead of wrap.
module mem_traffic_profiler
    import mem_traffic_profiler_pkg::*;
#(
    parameter int unsigned data_width_p   = 32,
    parameter int unsigned addr_width_p   = 28,
    parameter int unsigned x_cord_width_p = 7,
    parameter int unsigned y_cord_width_p = 7,
    parameter int unsigned num_ports_p    = 1,
    parameter int unsigned ctr_width_p    = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    mem_traffic_profiler_if.master  ifc,
    input  logic [31:0]             global_ctr_i,
    input  logic                    print_stat_v_i,
    input  logic [data_width_p-1:0] print_stat_tag_i,
    output logic                    busy_o,
    output logic                    overrun_o
);

    localparam int unsigned port_id_width_lp = mem_prof_safe_clog2(num_ports_p);
    localparam int unsigned packet_width_lp  =
        mem_prof_packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);
    localparam int unsigned op_lsb_lp        =
        mem_prof_op_v2_lsb(data_width_p, x_cord_width_p, y_cord_width_p);
    localparam int unsigned num_ctrs_lp      = num_ports_p * mem_prof_num_ops_gp;
    localparam int unsigned idx_width_lp     = $clog2(num_ctrs_lp);
    localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(num_ctrs_lp - 1);

    typedef enum logic {e_idle, e_dump} state_e;

    state_e                  state;
    logic [num_ctrs_lp-1:0]  hit;
    logic [ctr_width_p-1:0]  live [num_ctrs_lp];
    logic [ctr_width_p-1:0]  snap [num_ctrs_lp];
    logic [idx_width_lp-1:0] index;
    logic [idx_width_lp-1:0] index_next;
    logic [ctr_width_p-1:0]  first_count;
    logic [ctr_width_p-1:0]  next_count;
`ifdef MEM_TRAFFIC_PROFILER_SATURATE_EN
    logic [num_ctrs_lp-1:0]  live_sat;
    logic [num_ctrs_lp-1:0]  snap_sat;
`endif

    // Only the op_v2 field is profiled; the rest of each packet is ignored.
    logic unused_packet_bits;
    assign unused_packet_bits = ^ifc.packet_i;

    // One-hot (per port) event strobes, laid out port-major, op-minor.
    always_comb begin
        hit = '0;
        for (int unsigned p = 0; p < num_ports_p; p++) begin
            for (int unsigned o = 0; o < mem_prof_num_ops_gp; o++) begin
                hit[p*mem_prof_num_ops_gp + o] =
                    ifc.packet_v_i[p] & ifc.packet_yumi_i[p]
                    & (mem_prof_decode_op(ifc.packet_i[p*packet_width_lp + op_lsb_lp +: 4])
                       == mem_prof_op_e'(3'(o)));
            end
        end
    end

    for (genvar i = 0; i < num_ctrs_lp; i++) begin : g_ctr
        mem_traffic_prof_counter #(
            .ctr_width_p(ctr_width_p)
        ) u_ctr (
            .clk  (clk_i),
            .reset(reset_i),
            .incr (hit[i]),
            .count(live[i])
`ifdef MEM_TRAFFIC_PROFILER_SATURATE_EN
            ,
            .sat  (live_sat[i])
`endif
        );
    end

    // The first record comes straight from the live bank (pre-increment
    // value, same as what lands in the snapshot); later records are
    // preloaded from the snapshot so the outputs stay registered.
    always_comb begin
        index_next  = (index == last_idx_lp) ? '0 : index + idx_width_lp'(1);
        first_count = live[0];
        next_count  = snap[index_next];
`ifdef MEM_TRAFFIC_PROFILER_SATURATE_EN
        if (live_sat[0]) first_count = '1;
        if (snap_sat[index_next]) next_count = '1;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state            <= e_idle;
            index            <= '0;
            busy_o           <= 1'b0;
            overrun_o        <= 1'b0;
            ifc.stat_v_o     <= 1'b0;
            ifc.stat_last_o  <= 1'b0;
            ifc.stat_tag_o   <= '0;
            ifc.stat_ctr_o   <= '0;
            ifc.stat_port_o  <= '0;
            ifc.stat_op_o    <= '0;
            ifc.stat_count_o <= '0;
            for (int unsigned i = 0; i < num_ctrs_lp; i++) begin
                snap[i] <= '0;
            end
`ifdef MEM_TRAFFIC_PROFILER_SATURATE_EN
            snap_sat <= '0;
`endif
        end else begin
            case (state)
                e_idle: begin
                    if (print_stat_v_i) begin
                        for (int unsigned i = 0; i < num_ctrs_lp; i++) begin
                            snap[i] <= live[i];
                        end
`ifdef MEM_TRAFFIC_PROFILER_SATURATE_EN
                        snap_sat <= live_sat;
`endif
                        ifc.stat_tag_o   <= print_stat_tag_i;
                        ifc.stat_ctr_o   <= global_ctr_i;
                        index            <= '0;
                        ifc.stat_port_o  <= '0;
                        ifc.stat_op_o    <= 3'(e_prof_ld);
                        ifc.stat_count_o <= first_count;
                        ifc.stat_last_o  <= 1'b0;
                        ifc.stat_v_o     <= 1'b1;
                        busy_o           <= 1'b1;
                        state            <= e_dump;
                    end
                end
                e_dump: begin
                    if (print_stat_v_i) begin
                        overrun_o <= 1'b1;
                    end
                    if (ifc.stat_yumi_i) begin
                        if (ifc.stat_last_o) begin
                            ifc.stat_v_o    <= 1'b0;
                            ifc.stat_last_o <= 1'b0;
                            busy_o          <= 1'b0;
                            state           <= e_idle;
                        end else begin
                            index            <= index_next;
                            ifc.stat_count_o <= next_count;
                            ifc.stat_last_o  <= (index_next == last_idx_lp);
                            // Port/op walk alongside index to avoid a divide by 5.
                            if (ifc.stat_op_o == 3'(e_prof_other)) begin
                                ifc.stat_op_o   <= 3'(e_prof_ld);
                                ifc.stat_port_o <= ifc.stat_port_o + port_id_width_lp'(1);
                            end else begin
                                ifc.stat_op_o <= ifc.stat_op_o + 3'd1;
                            end
                        end
                    end
                end
                default: state <= e_idle;
            endcase
        end
    end

    yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) ifc.stat_yumi_i |-> ifc.stat_v_o
    );

endmodule

// File: tb/tb_mem_traffic_profiler.sv
// Self-checking bench for mem_traffic_profiler (2 ports, 8-bit counters).
// A queue-based reference model tracks per-port/per-op counts and the
// pending record list of a dump; outputs are compared every cycle.
module tb_mem_traffic_profiler;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 28;
    localparam int unsigned XW = 6;
    localparam int unsigned YW = 5;
    localparam int unsigned NP = 2;
    localparam int unsigned CW = 8;
    localparam int unsigned NOPS = 5;
    localparam int unsigned NC = NP * NOPS;
    localparam int unsigned PW = AW + 4 + 5 + DW + 2 * (XW + YW);
    localparam int unsigned OP_LSB = 5 + DW + 2 * (XW + YW);
    localparam int unsigned CMAX = (1 << CW) - 1;
`ifdef MEM_TRAFFIC_PROFILER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [31:0]   global_ctr;
    logic          print_v;
    logic [DW-1:0] print_tag;
    logic          busy;
    logic          overrun;

    mem_traffic_profiler_if #(
        .data_width_p(DW), .addr_width_p(AW), .x_cord_width_p(XW),
        .y_cord_width_p(YW), .num_ports_p(NP), .ctr_width_p(CW)
    ) ifc ();

    mem_traffic_profiler #(
        .data_width_p(DW), .addr_width_p(AW), .x_cord_width_p(XW),
        .y_cord_width_p(YW), .num_ports_p(NP), .ctr_width_p(CW)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .ifc             (ifc),
        .global_ctr_i    (global_ctr),
        .print_stat_v_i  (print_v),
        .print_stat_tag_i(print_tag),
        .busy_o          (busy),
        .overrun_o       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned port;
        int unsigned op;
        int unsigned count;
    } rec_t;

    int unsigned m_live [NP][NOPS];
    rec_t        m_q [$];
    logic [31:0] m_tag;
    logic [31:0] m_ctr;
    bit          m_overrun;
    int unsigned pkt_op [NP];
    int unsigned got_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned op_class(input int unsigned code);
        case (code)
            0:       return 0;
            1:       return 1;
            4:       return 2;
            8:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int unsigned bump(input int unsigned v);
        if (SAT) return (v == CMAX) ? v : v + 1;
        return (v + 1) & CMAX;
    endfunction

    function automatic int unsigned pick_op();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return 1;
            2:       return 4;
            3:       return 8;
            default: return $urandom_range(0, 15);
        endcase
    endfunction

    task automatic set_port(input int unsigned p, input bit v, input bit y, input int unsigned op);
        logic [PW-1:0] pk;
        pk = PW'({$urandom, $urandom, $urandom});
        pk[OP_LSB +: 4] = 4'(op);
        ifc.packet_i[p*PW +: PW] = pk;
        ifc.packet_v_i[p]    = v;
        ifc.packet_yumi_i[p] = y;
        pkt_op[p] = op;
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, 0);
        print_v = 1'b0;
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++)
            for (int o = 0; o < NOPS; o++) m_live[p][o] = 0;
        m_q.delete();
        m_tag = '0;
        m_ctr = '0;
        m_overrun = 1'b0;
    endtask

    // One clock: advance the model with the inputs in force, then compare.
    task automatic tick();
        rec_t r;
        int unsigned cls;
        if (ifc.stat_v_o === 1'b1 && ifc.stat_yumi_i === 1'b1)
            got_q.push_back(32'(ifc.stat_count_o));
        if (m_q.size() != 0) begin
            if (print_v) m_overrun = 1'b1;
            if (ifc.stat_yumi_i) void'(m_q.pop_front());
        end else if (print_v) begin
            m_tag = print_tag;
            m_ctr = global_ctr;
            for (int p = 0; p < NP; p++)
                for (int o = 0; o < NOPS; o++)
                    m_q.push_back('{port: p, op: o, count: m_live[p][o]});
        end
        for (int p = 0; p < NP; p++) begin
            if (ifc.packet_v_i[p] && ifc.packet_yumi_i[p]) begin
                cls = op_class(pkt_op[p]);
                m_live[p][cls] = bump(m_live[p][cls]);
            end
        end
        @(posedge clk);
        #1;
        global_ctr = global_ctr + 32'd1;
        check("stat_v", 64'(ifc.stat_v_o), 64'(m_q.size() != 0));
        check("busy", 64'(busy), 64'(m_q.size() != 0));
        check("overrun", 64'(overrun), 64'(m_overrun));
        if (m_q.size() != 0) begin
            r = m_q[0];
            check("port", 64'(ifc.stat_port_o), 64'(r.port));
            check("op", 64'(ifc.stat_op_o), 64'(r.op));
            check("count", 64'(ifc.stat_count_o), 64'(r.count));
            check("last", 64'(ifc.stat_last_o), 64'(m_q.size() == 1));
            check("tag", 64'(ifc.stat_tag_o), 64'(m_tag));
            check("ctr", 64'(ifc.stat_ctr_o), 64'(m_ctr));
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        ifc.stat_yumi_i = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        global_ctr = global_ctr + 32'd1;
        model_clear();
        check("rst_v", 64'(ifc.stat_v_o), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_last", 64'(ifc.stat_last_o), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_count", 64'(ifc.stat_count_o), 64'd0);
        check("rst_tag", 64'(ifc.stat_tag_o), 64'd0);
        check("rst_ctr", 64'(ifc.stat_ctr_o), 64'd0);
        check("rst_port", 64'(ifc.stat_port_o), 64'd0);
        check("rst_op", 64'(ifc.stat_op_o), 64'd0);
        reset = 1'b0;
    endtask

    task automatic request(input logic [DW-1:0] tag);
        print_v = 1'b1;
        print_tag = tag;
        tick();
        print_v = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && m_q.size() != 0; i++) begin
            ifc.stat_yumi_i = 1'b1;
            tick();
        end
        ifc.stat_yumi_i = 1'b0;
        check("drain_done", 64'(ifc.stat_v_o), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        global_ctr = 32'h100;
        print_tag = '0;
        ifc.stat_yumi_i = 1'b0;
        idle_inputs();
        do_reset();

        // 3 loads, 2 stores, 1 amoswap on port 0, then a dump with tag 7.
        for (int i = 0; i < 6; i++) begin
            set_port(0, 1'b1, 1'b1, (i < 3) ? 0 : (i < 5) ? 1 : 4);
            tick();
        end
        idle_inputs();
        tick();
        got_q.delete();
        request(32'h7);
        drain(NC + 4);
        check("d1_nrec", 64'(got_q.size()), 64'(NC));
        check("d1_ld", 64'(got_q[0]), 64'd3);
        check("d1_st", 64'(got_q[1]), 64'd2);
        check("d1_swap", 64'(got_q[2]), 64'd1);
        check("d1_or", 64'(got_q[3]), 64'd0);
        check("d1_oth", 64'(got_q[4]), 64'd0);

        // Port 1 valid without yumi does not count; simultaneous events do.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_port(1, 1'b1, 1'b0, pick_op());
            tick();
        end
        set_port(0, 1'b1, 1'b1, 1);
        set_port(1, 1'b1, 1'b1, 8);
        tick();
        idle_inputs();
        got_q.delete();
        request(32'h22);
        drain(NC + 4);
        check("d2_p0st", 64'(got_q[1]), 64'd1);
        check("d2_p1ld", 64'(got_q[5]), 64'd0);
        check("d2_p1or", 64'(got_q[8]), 64'd1);

        // Request in the same cycle as a load: snapshot is pre-increment.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_port(0, 1'b1, 1'b1, 0);
            tick();
        end
        got_q.delete();
        request(32'h33);
        idle_inputs();
        drain(NC + 4);
        check("d3_pre", 64'(got_q[0]), 64'd4);
        got_q.delete();
        request(32'h34);
        drain(NC + 4);
        check("d3_post", 64'(got_q[0]), 64'd5);

        // Back-to-back: request right after the last yumi is accepted.
        request(32'h35);
        check("b2b_busy", 64'(busy), 64'd1);
        drain(NC + 4);

        // Request during a stalled dump: overrun set, dump unaffected.
        request(32'hA5);
        for (int i = 0; i < 20; i++) begin
            set_port(0, 1'b1, 1'b1, pick_op());
            if (i == 5) begin
                print_v = 1'b1;
                print_tag = 32'h5A;
            end
            tick();
            print_v = 1'b0;
        end
        idle_inputs();
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_tag", 64'(ifc.stat_tag_o), 64'hA5);
        drain(NC + 4);
        check("ovr_sticky", 64'(overrun), 64'd1);

        // 257 loads on an 8-bit counter.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            set_port(0, 1'b1, 1'b1, 0);
            tick();
        end
        idle_inputs();
        got_q.delete();
        request(32'h44);
        drain(NC + 4);
        check("wrap_ld", 64'(got_q[0]), SAT ? 64'd255 : 64'd1);

        // Reset in the middle of a dump, then a clean dump of zeros.
        for (int i = 0; i < 3; i++) begin
            set_port(1, 1'b1, 1'b1, 1);
            tick();
        end
        idle_inputs();
        request(32'h55);
        ifc.stat_yumi_i = 1'b1;
        tick();
        tick();
        ifc.stat_yumi_i = 1'b0;
        do_reset();
        got_q.delete();
        request(32'h66);
        drain(NC + 4);
        check("rz_nrec", 64'(got_q.size()), 64'(NC));
        for (int i = 0; i < NC; i++) check("rz_zero", 64'(got_q[i]), 64'd0);

        // Randomized traffic with sporadic requests and consumer stalls.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++)
                set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_op());
            print_v = ($urandom_range(0, 99) < 4);
            print_tag = $urandom;
            ifc.stat_yumi_i = (m_q.size() != 0) && ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end
        idle_inputs();
        drain(4 * NC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_traffic_profiler.md
Name: mem_traffic_profiler

Overview:
- Multi-port successor to the single-port infinite-memory profiler.
- Counts accepted manycore request packets per port and per op class; counter width and port count are parametrised.
- On request, snapshots all counters and streams them out as valid/yumi records, replacing simulation-only file writes; the block is synthesizable.
- Sits beside memory endpoints (infinite mem, DRAM ctrl) and taps their request-side handshakes.

Parameters:
- data_width_p, "inv", manycore data width; also the tag width.
- addr_width_p, "inv", manycore address width.
- x_cord_width_p, "inv", packet X coordinate width.
- y_cord_width_p, "inv", packet Y coordinate width.
- num_ports_p, 1, number of tapped request ports (1..16).
- ctr_width_p, 32, width of each event counter (8..64).
- port_id_width_lp, derived, `BSG_SAFE_CLOG2(num_ports_p)`.
- packet_width_lp, derived, `bsg_manycore_packet_width(addr_width_p,data_width_p,x_cord_width_p,y_cord_width_p)`.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- packet_v_i  in  num_ports_p  per-port packet valid.
- packet_i  in  num_ports_p*packet_width_lp  per-port packets, port 0 in the LSBs.
- packet_yumi_i  in  num_ports_p  per-port consumer accept.
- global_ctr_i  in  32  timestamp.
- print_stat_v_i  in  1  snapshot request.
- print_stat_tag_i  in  data_width_p  snapshot tag.
- busy_o  out  1  a dump is in progress.
- overrun_o  out  1  sticky flag: a request arrived while busy.
- stat_v_o  out  1  output record valid.
- stat_tag_o  out  data_width_p  tag latched at the snapshot.
- stat_ctr_o  out  32  global_ctr_i latched at the snapshot.
- stat_port_o  out  port_id_width_lp  port index of the record.
- stat_op_o  out  3  op class of the record.
- stat_count_o  out  ctr_width_p  count value.
- stat_last_o  out  1  marks the final record of a dump.
- stat_yumi_i  in  1  consumer takes the record.

Behaviour:
- Event definition: an event occurs on port p when packet_v_i[p] & packet_yumi_i[p].
  - The op class is decoded from op_v2: LD=0 (e_remote_load), ST=1 (e_remote_store), AMOSWAP=2 (e_remote_amoswap), AMOOR=3 (e_remote_amoor), OTHER=4 (any other op).
- Counters: there are num_ports_p*5 live counters, each ctr_width_p wide.
  - An event increments its counter by 1 on the next clk_i edge.
  - All ports count independently in the same cycle.
  - Default overflow behaviour: wrap modulo 2^ctr_width_p.
- FSM states are IDLE and DUMP.
- IDLE:
  - If print_stat_v_i is high, on the same edge:
    - copy every live counter into the snapshot bank, using the pre-increment value;
    - latch print_stat_tag_i and global_ctr_i;
    - set index=0 and go to DUMP.
  - An event in that same cycle still increments the live counter.
- DUMP:
  - stat_v_o=1. The record comes from snapshot[index], where port=index/5 and op=index%5. Order is port-major, op-minor.
  - stat_last_o=1 when index==num_ports_p*5-1.
  - On stat_yumi_i, advance index. After the last record, return to IDLE.
  - Output fields are stable while stat_v_o & ~stat_yumi_i. stat_yumi_i while stat_v_o=0 is illegal (assertion).
  - busy_o=1 in DUMP.
- Request during DUMP:
  - print_stat_v_i is ignored and overrun_o is set, sticky until reset.
  - The in-progress dump is unaffected.
- Back-to-back: a request in the cycle after the last yumi is accepted (the FSM is back in IDLE).
- Counting never stalls. Live counters keep counting during DUMP and are never cleared except by reset.
- Latency: request edge to first stat_v_o is 1 cycle. Each record is 1 cycle when stat_yumi_i is held high, so a full dump takes num_ports_p*5 cycles.
- Reset (synchronous, active-high):
  - Live counters, snapshot bank, index, latched tag/ctr and overrun_o go to 0; FSM goes to IDLE.
  - Outputs: stat_v_o=0, busy_o=0, stat_last_o=0; data outputs=0.
  - Reset during DUMP aborts the dump: stat_v_o is 0 from the next edge, and no partial record is retained.

Optional Feature:
- Macro: MEM_TRAFFIC_PROFILER_SATURATE_EN.
- Defined: counters saturate at 2^ctr_width_p-1; further events hold that value. A per-counter saturated bit is captured with the snapshot, and stat_count_o reads all-ones for a saturated counter.
- Undefined: counters wrap modulo 2^ctr_width_p.
- The interface is identical in both cases.

Decomposition:
- Package mem_traffic_profiler_pkg holds:
  - typedef enum logic [2:0] mem_prof_op_e {e_prof_ld, e_prof_st, e_prof_amoswap, e_prof_amoor, e_prof_other};
  - localparam mem_prof_num_ops_gp = 5;
  - function to decode op_v2 into mem_prof_op_e.
- Sub-module mem_traffic_prof_counter: one ctr_width_p event counter with increment and reset, including saturation logic under the macro. It is instantiated num_ports_p*5 times.

Test Plan:
- 1 port; 3 loads, 2 stores, 1 amoswap accepted, then a request with tag 0x7, yumi held high -> 5 records, counts 3,2,1,0,0, tag 0x7, stat_last_o on record 4.
- 2 ports; port 1 has v=1 with yumi=0 for 10 cycles -> its counts stay 0. A simultaneous port 0 store and port 1 amoor in one cycle -> each counter reads 1.
- Request arrives in the same cycle as a load event (live count was 4) -> snapshot LD=4. A second dump later reads 5.
- Request during DUMP with stat_yumi_i held low for 20 cycles -> overrun_o=1, records stable, the dump completes with the original tag.
- ctr_width_p=8, 257 loads -> LD=1 with the macro undefined; LD=255 with MEM_TRAFFIC_PROFILER_SATURATE_EN defined.
- Reset asserted at record 2 of 10 -> stat_v_o=0 next cycle, all counts 0; a new dump then reads all zeros.
